cb_zigzag_serializer: RTL

Downstream neighbour of the Cb quantizer. It captures each quantized 8x8 Cb block, strobed by the quantizer's `out_enable`, into a two-bank ping-pong buffer. It then streams the 64 coefficients one per handshake in JPEG zigzag order over a valid/ready interface to the Cb entropy coder. The DC coefficient is replaced by its difference from the previous block's DC.

---
 rtl/cb_zigzag_serializer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cb_zigzag_serializer.sv
// Cb zigzag serializer: captures quantized 8x8 Cb blocks into a ping-pong
// buffer and streams them in JPEG zigzag order over valid/ready. The DC
// coefficient is sent as the difference from the previous block's DC.
module cb_zigzag_serializer (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic signed [10:0]  Q [0:7][0:7],
    input  logic                pred_clear,
    input  logic                coef_ready,
    output logic                coef_valid,
    output logic signed [11:0]  coef_out,
    output logic [5:0]          coef_idx,
    output logic                coef_last,
    output logic                in_ready,
    output logic                overflow
);

    typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

    // Zigzag order: entry k is the raster index (r*8+c) sent at position k.
    localparam logic [5:0] ZZ [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic signed [11:0] sext12(input logic signed [10:0] v);
        return {v[10], v};
    endfunction

    // 11-bit minus 11-bit always fits in 12 bits, so no saturation is needed.
    function automatic logic signed [11:0] dc_diff(input logic signed [10:0] cur,
                                                   input logic signed [10:0] prev);
        return sext12(cur) - sext12(prev);
    endfunction

    logic signed [10:0] r_bank0 [0:63];
    logic signed [10:0] r_bank1 [0:63];
    logic [1:0]         r_full;
    logic               r_wr_sel;
    logic               r_rd_sel;
    logic [5:0]         r_k;
    logic signed [10:0] r_dc_pred;
    logic               r_overflow;
    state_t             r_state;
    state_t             w_state_nxt;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_hs;
    logic               w_last_hs;
    logic               w_other_fills;
    logic [5:0]         w_raster;
    logic signed [10:0] w_coef;

    assign w_in_ready    = ~(r_full[0] & r_full[1]);
    assign w_accept      = enable & w_in_ready;
    assign w_hs          = coef_valid & coef_ready;
    assign w_last_hs     = w_hs & (r_k == 6'd63);
    // The next bank is (or becomes this cycle) full, so emission continues without a bubble.
    assign w_other_fills = r_full[~r_rd_sel] | (w_accept & (r_wr_sel != r_rd_sel));
    assign w_raster      = ZZ[r_k];
    assign w_coef        = r_rd_sel ? r_bank1[w_raster] : r_bank0[w_raster];

    // Capture a whole block into bank 0 when it is the write target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) r_bank0[i] <= '0;
        end else if (w_accept && !r_wr_sel) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    r_bank0[r*8+c] <= Q[r][c];
        end
    end

    // Capture a whole block into bank 1 when it is the write target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) r_bank1[i] <= '0;
        end else if (w_accept && r_wr_sel) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    r_bank1[r*8+c] <= Q[r][c];
        end
    end

    // Bank bookkeeping, read counter, DC predictor and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full     <= 2'b00;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_k        <= 6'd0;
            r_dc_pred  <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Release happens before set; the write target is never the bank being read.
            if (w_last_hs) r_full[r_rd_sel] <= 1'b0;
            if (w_accept) begin
                r_full[r_wr_sel] <= 1'b1;
                r_wr_sel         <= ~r_wr_sel;
            end
            if (enable && !w_in_ready) r_overflow <= 1'b1;
            if (w_hs) begin
                if (r_k == 6'd63) begin
                    r_k      <= 6'd0;
                    r_rd_sel <= ~r_rd_sel;
                end else begin
                    r_k <= r_k + 6'd1;
                end
            end
            if (pred_clear)              r_dc_pred <= '0;
            else if (w_hs && r_k == 6'd0) r_dc_pred <= w_coef;
        end
    end

    // Read-side state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Read-side next state: enter EMIT with the write that fills the read bank.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && (r_wr_sel == r_rd_sel)) w_state_nxt = S_EMIT;
            S_EMIT: if (w_last_hs && !w_other_fills)        w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read-side outputs, derived from the current bank entry and counter.
    always_comb begin
        coef_valid = (r_state == S_EMIT);
        coef_idx   = r_k;
        coef_last  = (r_state == S_EMIT) && (r_k == 6'd63);
        coef_out   = (r_k == 6'd0) ? dc_diff(w_coef, r_dc_pred) : sext12(w_coef);
        in_ready   = w_in_ready;
        overflow   = r_overflow;
    end

endmodule
